// File: rtl/div8_pkg.sv
// ============================================================================
// Module      : div8_pkg
// Description : Shared constants and the state encoding for the sequential
//               8-bit divider (div8_seq) and its subtract/borrow step.
// Optional    : DIV_SIGNED_EN (consumed by div8_seq, not by this package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div8_pkg;

  // Operand/result width and the iteration count of the divider.
  localparam int DIV_W = 8;

  // Counter must hold the value DIV_W, hence DIV_W+1 distinct values.
  localparam int CNT_W = $clog2(DIV_W + 1);

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } div_state_t;

endpackage : div8_pkg

`default_nettype wire

// File: rtl/div8_step.sv
// ============================================================================
// Module      : div8_step
// Description : One restoring-division step. Shifts the dividend MSB into the
//               partial remainder and trial-subtracts the divisor.
// Ports       : rem          in  WIDTH  current partial remainder
//               dividend_msb in  1      bit shifted in from the dividend
//               divisor      in  WIDTH  divisor
//               next_rem     out WIDTH  partial remainder after this step
//               q_bit        out 1      quotient bit (1 = subtraction kept)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div8_step
  import div8_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] sum;
  logic             carry;

  assign shifted = {rem, dividend_msb};

  // shifted - {0,divisor} done as shifted + ~{0,divisor} + 1 over WIDTH+1
  // bits; the carry out of that adder is 1 exactly when there is no borrow,
  // matching the subtractor stage this block sits behind.
  assign sum   = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign carry = sum[WIDTH+1];

  // When the subtraction is kept the result is below the divisor, so the
  // low WIDTH bits hold it entirely. On borrow the shifted value is restored;
  // its top bit is zero there because rem < divisor before the shift.
  assign next_rem = carry ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_bit    = carry;

endmodule : div8_step

`default_nettype wire

// File: rtl/div8_seq.sv
// ============================================================================
// Module      : div8_seq
// Description : Sequential restoring divider, one quotient bit per clock.
//               START in IDLE/FIN latches A/B; DONE pulses for one cycle when
//               Q/R/DIVZ are updated. Divide by zero finishes after one edge
//               with Q=all ones, R=A, DIVZ=1.
// Ports       : clk   in  1      rising-edge clock
//               rst   in  1      synchronous active-high reset
//               START in  1      one-cycle request (accepted in IDLE/FIN)
//               A     in  WIDTH  dividend
//               B     in  WIDTH  divisor
//               BUSY  out 1      high while iterating
//               DONE  out 1      one-cycle completion pulse
//               Q     out WIDTH  quotient (held)
//               R     out WIDTH  remainder (held)
//               DIVZ  out 1      divide-by-zero flag (held)
// Optional    : DIV_SIGNED_EN - two's-complement operands; magnitudes are
//               divided, Q negated when signs differ, R takes the sign of A.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div8_seq
  import div8_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DIVZ
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state;
  div_state_t       state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;       // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] dsr;       // divisor
  logic [WIDTH-1:0] rem;       // partial remainder
  logic [WIDTH-1:0] next_rem;
  logic             q_bit;
  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign accept    = START && ((state == ST_IDLE) || (state == ST_FIN));
  assign last_step = (state == ST_RUN) && (cnt == CW'(1));

  // Quotient as it stands after the final shift.
  assign q_raw = {dvd[WIDTH-2:0], q_bit};

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Unary minus of the most negative value wraps to itself, which read as
  // unsigned is exactly its magnitude.
  assign a_mag = A[WIDTH-1] ? -A : A;
  assign b_mag = B[WIDTH-1] ? -B : B;
  assign q_fin = neg_q ? -q_raw : q_raw;
  assign r_fin = neg_r ? -next_rem : next_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
      neg_r <= A[WIDTH-1];
    end
  end
`else
  assign a_mag = A;
  assign b_mag = B;
  assign q_fin = q_raw;
  assign r_fin = next_rem;
`endif

  div8_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem),
    .dividend_msb (dvd[WIDTH-1]),
    .divisor      (dsr),
    .next_rem     (next_rem),
    .q_bit        (q_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (START) state_nxt = (B == '0) ? ST_FIN : ST_RUN;
      end
      ST_RUN: begin
        if (cnt == CW'(1)) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        if (START) state_nxt = (B == '0) ? ST_FIN : ST_RUN;
        else       state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign BUSY = (state == ST_RUN);
  assign DONE = (state == ST_FIN);

  // Working registers and held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dvd  <= '0;
      dsr  <= '0;
      rem  <= '0;
      Q    <= '0;
      R    <= '0;
      DIVZ <= 1'b0;
    end else if (accept) begin
      dvd <= a_mag;
      dsr <= b_mag;
      rem <= '0;
      if (B == '0) begin
        // Result is known immediately; the raw dividend is reported as R.
        cnt  <= '0;
        Q    <= '1;
        R    <= A;
        DIVZ <= 1'b1;
      end else begin
        cnt <= CW'(WIDTH);
      end
    end else if (state == ST_RUN) begin
      rem <= next_rem;
      dvd <= q_raw;
      cnt <= cnt - CW'(1);
      if (last_step) begin
        Q    <= q_fin;
        R    <= r_fin;
        DIVZ <= 1'b0;
      end
    end
  end

endmodule : div8_seq

`default_nettype wire

// File: tb/tb_div8_seq.sv
// ============================================================================
// Module      : tb_div8_seq
// Description : Self-checking bench for div8_seq: table of directed divisions
//               plus hand-written reset-abort and back-to-back sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div8_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       START;
  logic [7:0] A;
  logic [7:0] B;
  logic       BUSY;
  logic       DONE;
  logic [7:0] Q;
  logic [7:0] R;
  logic       DIVZ;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div8_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .START (START),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .Q     (Q),
    .R     (R),
    .DIVZ  (DIVZ)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       divz;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Caller is at a negedge. Issues a one-cycle START, then waits (bounded)
  // for DONE. n = negedges seen up to and including the DONE cycle,
  // busy = number of those cycles with BUSY high.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output int n, output int busy, output logic seen);
    START = 1'b1;
    A     = a;
    B     = b;
    @(posedge clk);
    #1 START = 1'b0;
    n    = 0;
    busy = 0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      busy += int'(BUSY);
      if (DONE) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Bounded wait for DONE while keeping START high and scrambling A/B.
  task automatic wait_done_scramble(output int n, output logic seen);
    n    = 0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (DONE) begin
        seen = 1'b1;
        break;
      end
      A = 8'($urandom_range(0, 255));
      B = 8'($urandom_range(1, 255));
    end
  endtask

  initial begin
    int         n;
    int         busy;
    int         dones;
    logic       seen;
    logic [7:0] hq;
    logic [7:0] hr;

    vecs.push_back('{8'd100, 8'd7,   8'd14,  8'd2,   1'b0});
    vecs.push_back('{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1});
    vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0,   1'b0});
    vecs.push_back('{8'd0,   8'd9,   8'd0,   8'd0,   1'b0});
    vecs.push_back('{8'd7,   8'd200, 8'd0,   8'd7,   1'b0});
    vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,   1'b0});
    vecs.push_back('{8'd20,  8'd3,   8'd6,   8'd2,   1'b0});
`ifdef DIV_SIGNED_EN
    vecs.push_back('{8'hF9,  8'd2,   8'hFD,  8'hFF,  1'b0});
    vecs.push_back('{8'd7,   8'hFE,  8'hFD,  8'd1,   1'b0});
    vecs.push_back('{8'h80,  8'hFF,  8'h80,  8'd0,   1'b0});
    vecs.push_back('{8'hF9,  8'd0,   8'hFF,  8'hF9,  1'b1});
`endif

    // Reset state.
    rst   = 1'b1;
    START = 1'b0;
    A     = 8'd0;
    B     = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", int'(BUSY), 0);
    check("reset_done", int'(DONE), 0);
    check("reset_q",    int'(Q),    0);
    check("reset_r",    int'(R),    0);
    check("reset_divz", int'(DIVZ), 0);

    // Directed table.
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, n, busy, seen);
      check($sformatf("v%0d_done_seen", i), int'(seen), 1);
      check($sformatf("v%0d_latency", i), n - 1, vecs[i].divz ? 0 : 8);
      check($sformatf("v%0d_busy_cycles", i), busy, vecs[i].divz ? 0 : 8);
      check($sformatf("v%0d_q", i), int'(Q), int'(vecs[i].q));
      check($sformatf("v%0d_r", i), int'(R), int'(vecs[i].r));
      check($sformatf("v%0d_divz", i), int'(DIVZ), int'(vecs[i].divz));
      hq = vecs[i].q;
      hr = vecs[i].r;
      A  = ~vecs[i].a;
      B  = 8'd3;
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), int'(DONE), 0);
      check($sformatf("v%0d_q_hold", i), int'(Q), int'(hq));
      check($sformatf("v%0d_r_hold", i), int'(R), int'(hr));
    end

    // Reset in the 4th RUN cycle aborts the operation.
    START = 1'b1;
    A     = 8'd100;
    B     = 8'd7;
    @(posedge clk);
    #1 START = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("abort_busy_before_rst", int'(BUSY), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(BUSY), 0);
    check("abort_q",    int'(Q),    0);
    check("abort_r",    int'(R),    0);
    check("abort_divz", int'(DIVZ), 0);
    dones = int'(DONE);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      dones += int'(DONE);
    end
    check("abort_no_done", dones, 0);
    do_op(8'd10, 8'd8, n, busy, seen);
    check("after_abort_latency", n - 1, 8);
    check("after_abort_q", int'(Q), 1);
    check("after_abort_r", int'(R), 2);

    // START held through RUN with A/B scrambled, then a back-to-back START
    // in the FIN cycle.
    START = 1'b1;
    A     = 8'd100;
    B     = 8'd7;
    @(posedge clk);
    wait_done_scramble(n, seen);
    check("held_done_seen", int'(seen), 1);
    check("held_latency", n - 1, 8);
    check("held_q", int'(Q), 14);
    check("held_r", int'(R), 2);
    do_op(8'd20, 8'd3, n, busy, seen);
    check("b2b_done_seen", int'(seen), 1);
    check("b2b_latency", n - 1, 8);
    check("b2b_q", int'(Q), 6);
    check("b2b_r", int'(R), 2);
    check("b2b_divz", int'(DIVZ), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_div8_seq

`default_nettype wire

// File: doc/div8_seq.md
Name: div8_seq

Overview:
- Sequential unsigned restoring divider for the 8-bit MIPS datapath.
- Sits directly downstream of the subtractor stage and reuses the same subtract/borrow step, one quotient bit per clock.
- Produces quotient and remainder for DIVU-style instructions.
- The controller starts it with a one-cycle START pulse and waits on DONE.

Parameters:
- WIDTH, 8, operand/result width; also the number of iterations.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- START  in  1  one-cycle request; sampled only in IDLE or DONE state
- A  in  WIDTH  dividend; sampled on the accepted START edge
- B  in  WIDTH  divisor; sampled on the accepted START edge
- BUSY  out  1  high while iterating
- DONE  out  1  one-cycle pulse; Q/R/DIVZ valid from this cycle
- Q  out  WIDTH  quotient, held until the next accepted START completes
- R  out  WIDTH  remainder, held likewise
- DIVZ  out  1  divide-by-zero flag, valid with DONE, held like Q/R

Behaviour:
- Clock and reset are fixed: one clock, clk; rst is synchronous and active-high.
- Reset (sync, rst=1 at an edge):
  - state=IDLE; BUSY=0, DONE=0, Q=0, R=0, DIVZ=0.
  - Iteration counter and working registers cleared.
  - rst overrides START.
- States are IDLE, RUN and FIN.
- IDLE, START=1:
  - Latch A into the shift register and B into the divisor register; clear the partial remainder.
  - If B==0: go to FIN next edge; Q=all ones, R=A, DIVZ=1, DONE=1. Latency is 1 edge.
  - Otherwise: go to RUN, BUSY=1, counter=WIDTH.
- RUN, each edge:
  - Form 9-bit trial = {rem, msb(dividend)} minus {0,divisor}.
  - No borrow: rem = trial[WIDTH-1:0] and the quotient bit is 1.
  - Borrow: rem = shifted value (restore) and the quotient bit is 0.
  - Dividend/quotient register shifts left one bit, inserting the quotient bit.
  - Counter decrements.
- End of RUN (edge where counter goes 1 to 0):
  - Go to FIN; Q and R load from the working registers; DIVZ=0; DONE=1; BUSY=0.
  - START at edge 0 gives DONE high in the cycle after edge WIDTH (8 cycles for WIDTH=8).
  - BUSY is high for exactly WIDTH cycles.
- FIN:
  - DONE=1 for exactly this one cycle.
  - START here is accepted exactly as in IDLE (back-to-back operation), otherwise go to IDLE.
- START is ignored during RUN, and A/B changes during RUN have no effect.
- Q/R/DIVZ never show intermediate values; they change only on the edge that enters FIN.
- rst during RUN aborts the operation: no DONE, and outputs return to reset values.
- Width rule: the partial remainder never exceeds divisor-1, so the 9-bit trial is sufficient. No overflow exists for unsigned operands.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - A and B are two's complement. Divide magnitudes unsigned.
  - Q is negated when the operand signs differ; R takes the sign of A.
  - The sign fix-up is applied on the edge entering FIN, so latency is unchanged.
  - -128 / -1 gives Q=8'h80, R=0, DIVZ=0.
  - Divide-by-zero gives Q=8'hFF, R=A, DIVZ=1.
- Undefined: purely unsigned behaviour as above; no sign logic is synthesised.

Decomposition:
- Package div8_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2;
  - DIV_W=8;
  - CNT_W=$clog2(DIV_W+1).
- One natural sub-module, div8_step, is combinational. It takes rem, dividend msb and divisor, and returns the next rem and the quotient bit. Its borrow convention matches the subtractor (carry-out=1 means no borrow).
- div8_seq holds the FSM, counter, registers and sign logic.

Test Plan:
- 100/7, START one cycle -> BUSY high 8 cycles; DONE pulse 8 cycles after START; Q=14, R=2, DIVZ=0; Q/R held afterwards.
- 5/0 -> DONE in the cycle after START; Q=8'hFF, R=5, DIVZ=1; BUSY never high.
- Boundaries: 255/1 -> Q=255, R=0. 0/9 -> Q=0, R=0. 7/200 -> Q=0, R=7. 255/255 -> Q=1, R=0.
- Reset during RUN (rst at 4th RUN cycle) -> all outputs 0, no DONE. Then 10/8 -> Q=1, R=2 after 8 cycles.
- START held high through RUN with A/B changed mid-run -> extra STARTs and A/B changes ignored; 100/7 result unchanged. START during the FIN cycle with 20/3 -> second DONE 8 cycles later with Q=6, R=2.
- DIV_SIGNED_EN defined:
  - -7/2 -> Q=8'hFD, R=8'hFF.
  - 7/-2 -> Q=8'hFD, R=1.
  - -128/-1 -> Q=8'h80, R=0.
  - latency still 8 cycles.
